fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//   Multicycle control FSM that sequences instruction fetch for the core datapath: resets PC,
//   waits fixed memory read latency, loads instruction register, classifies opcode, then commits
//   PC+4 through the ALU. Sits beside PC register, instruction register, ALU and instruction
//   memory; drives their control pins (reset, regWrite, Load_ir, ALU Seletor). Adds halt and trap.
// PARAMETERS
//   MEM_LATENCY  2       read cycles from PC valid to memory Dataout valid; legal range 1..15
//   ALU_ADD      3'b001  ALU selector code for A+B (PC+4)
//   ALU_NOP      3'b000  ALU selector driven outside EXEC
//   CNT_W        32      width of performance counters
// PORTS
//   CLK           in   1      clock, all logic on rising edge
//   RST           in   1      synchronous reset, active-high
//   halt_req      in   1      request stop at next instruction boundary; level-sensitive
//   opcode        in   7      instruction register bits [6:0]
//   pc_reset      out  1      PC register reset
//   pc_write      out  1      PC register write enable
//   alu_sel       out  3      ALU operation selector
//   ir_load       out  1      instruction register load enable
//   state         out  3      current state code (debug)
//   halted        out  1      high while in HALT
//   trap          out  1      high while in TRAP (illegal opcode)
//   instr_count   out  CNT_W  retired instruction count
//   halt_cycles   out  CNT_W  cycles spent in HALT
// BEHAVIOUR
//   - Moore FSM; all outputs decoded from registered state. Codes: RESET=0 FETCH=1 LOAD_IR=2
//     DECODE=3 EXEC=4 HALT=5 TRAP=6; 7 unused -> next state RESET.
//   - RST=1 at edge: state<=RESET, wait_cnt<=0, counters<=0; dominates all other inputs.
//   - RESET: pc_reset=1; next FETCH. pc_reset high during RST and one cycle after release.
//   - FETCH: wait_cnt counts 0..MEM_LATENCY-1; at MEM_LATENCY-1 -> LOAD_IR, wait_cnt<=0.
//   - LOAD_IR: ir_load=1 exactly one cycle; next DECODE.
//   - DECODE: opcode in {0110011,0010011,0000011,0100011,1100011,1100111,1101111,0110111,
//     0010111,1110011} -> EXEC; else -> TRAP.
//   - EXEC: pc_write=1, alu_sel=ALU_ADD one cycle; instr_count+1 (wraps at 2^CNT_W).
//     Next: halt_req ? HALT : FETCH.
//   - HALT: halted=1; halt_cycles+1 per cycle (wraps); halt_req=0 -> FETCH. halt_req is
//     sampled only in EXEC and HALT; asserting it mid-fetch takes effect at next EXEC.
//   - TRAP: trap=1, sticky; leaves only via RST; PC not advanced for the illegal instruction.
//   - Outside their states: pc_reset, pc_write, ir_load, halted, trap = 0; alu_sel=ALU_NOP.
//   - At most one of pc_reset/pc_write/ir_load high in any cycle.
//   - Throughput: MEM_LATENCY+3 cycles per instruction, no halt.
// CONFIGURATION
//   FETCH_SEQ_PERF_CNT_EN defined: instr_count and halt_cycles implemented as above.
//   Not defined: no counter flops; instr_count and halt_cycles tied to 0; FSM unchanged.
// TESTING (MEM_LATENCY=2, macro defined unless noted)
//   RST high 3 cycles, release -> pc_reset=1 through first post-reset cycle, state=1 next.
//   Legal opcode 0010011 stream -> ir_load every 5th cycle, pc_write 2 cycles later with
//     alu_sel=3'b001; instr_count=4 after 20 cycles.
//   Opcode 1111111 at DECODE -> state=6, trap=1 held 10 cycles, pc_write never set; RST clears.
//   halt_req=1 during FETCH, drop after 7 cycles in HALT -> enter HALT after EXEC,
//     halt_cycles=7, resume at FETCH, instr_count unchanged by halt.
//   RST asserted in LOAD_IR -> next cycle state=0, ir_load=0, counters=0.
//   Macro undefined, 3 instructions retired -> instr_count=0, halt_cycles=0, timing identical.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Multicycle Moore control FSM that sequences instruction fetch.
//            It holds the PC in reset, waits out the instruction-memory read
//            latency, pulses the instruction-register load, classifies the
//            opcode, then commits PC+4 through the ALU. Adds a halt state
//            (level-sensitive request, sampled at instruction boundaries) and
//            a sticky trap state for illegal opcodes.
// Ports    : CLK          clock, rising edge
//            RST          synchronous reset, active-high
//            halt_req     stop at next instruction boundary (level)
//            opcode[6:0]  instruction register bits [6:0]
//            pc_reset     PC register reset
//            pc_write     PC register write enable
//            alu_sel[2:0] ALU operation selector
//            ir_load      instruction register load enable
//            state[2:0]   current state code (debug)
//            halted       high while in HALT
//            trap         high while in TRAP
//            instr_count  retired instruction count (CNT_W bits)
//            halt_cycles  cycles spent in HALT (CNT_W bits)
// Config   : FETCH_SEQ_PERF_CNT_EN defined -> performance counters built;
//            undefined -> counters tied to zero, FSM unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter int unsigned MEM_LATENCY = 2,       // legal range 1..15
  parameter logic [2:0]  ALU_ADD     = 3'b001,
  parameter logic [2:0]  ALU_NOP     = 3'b000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             halt_req,
  input  logic [6:0]       opcode,
  output logic             pc_reset,
  output logic             pc_write,
  output logic [2:0]       alu_sel,
  output logic             ir_load,
  output logic [2:0]       state,
  output logic             halted,
  output logic             trap,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] halt_cycles
);

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_FETCH   = 3'd1,
    S_LOAD_IR = 3'd2,
    S_DECODE  = 3'd3,
    S_EXEC    = 3'd4,
    S_HALT    = 3'd5,
    S_TRAP    = 3'd6
  } state_t;

  // Terminal value of the memory wait counter.
  localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] wait_cnt_q;
  logic [3:0] wait_cnt_d;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011:
        is_legal = 1'b1;
      default:
        is_legal = 1'b0;
    endcase
  endfunction

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_RESET;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 4'd0;
    pc_reset   = 1'b0;
    pc_write   = 1'b0;
    ir_load    = 1'b0;
    alu_sel    = ALU_NOP;
    halted     = 1'b0;
    trap       = 1'b0;
    case (state_q)
      S_RESET: begin
        pc_reset = 1'b1;
        state_d  = S_FETCH;
      end
      S_FETCH: begin
        if (wait_cnt_q == LAT_LAST) begin
          state_d = S_LOAD_IR;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_LOAD_IR: begin
        ir_load = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = is_legal(opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        pc_write = 1'b1;
        alu_sel  = ALU_ADD;
        state_d  = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (!halt_req) begin
          state_d = S_FETCH;
        end
      end
      S_TRAP: begin
        // Sticky: only RST leaves this state; PC is never advanced.
        trap = 1'b1;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  assign state = state_q;

`ifdef FETCH_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] instr_count_q;
  logic [CNT_W-1:0] halt_cycles_q;

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_count_q <= '0;
      halt_cycles_q <= '0;
    end else begin
      if (state_q == S_EXEC) begin
        instr_count_q <= instr_count_q + 1'b1;
      end
      if (state_q == S_HALT) begin
        halt_cycles_q <= halt_cycles_q + 1'b1;
      end
    end
  end

  assign instr_count = instr_count_q;
  assign halt_cycles = halt_cycles_q;
`else
  assign instr_count = '0;
  assign halt_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer (MEM_LATENCY=2).
//            Expected ir_load / pc_write cycle numbers are queued when a
//            scenario is started and popped by a monitor when the DUT pulses
//            them. Counter expectations depend on FETCH_SEQ_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam int L     = 2;      // memory latency
  localparam int P     = L + 3;  // cycles per instruction
  localparam int CNT_W = 32;

  logic             CLK;
  logic             RST;
  logic             halt_req;
  logic [6:0]       opcode;
  logic             pc_reset;
  logic             pc_write;
  logic [2:0]       alu_sel;
  logic             ir_load;
  logic [2:0]       state;
  logic             halted;
  logic             trap;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] halt_cycles;

  fetch_sequencer #(
    .MEM_LATENCY(L),
    .ALU_ADD    (3'b001),
    .ALU_NOP    (3'b000),
    .CNT_W      (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .halt_req   (halt_req),
    .opcode     (opcode),
    .pc_reset   (pc_reset),
    .pc_write   (pc_write),
    .alu_sel    (alu_sel),
    .ir_load    (ir_load),
    .state      (state),
    .halted     (halted),
    .trap       (trap),
    .instr_count(instr_count),
    .halt_cycles(halt_cycles)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  int ir_q[$];
  int ex_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] cnt_exp(input int v);
`ifdef FETCH_SEQ_PERF_CNT_EN
    return 64'(v);
`else
    return 64'(v * 0);
`endif
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Queue one instruction's expected ir_load and (optional) pc_write cycles,
  // given the cycle at which FETCH begins.
  task automatic expect_instr(input int start, input bit retire);
    ir_q.push_back(start + L);
    if (retire) ex_q.push_back(start + L + 2);
  endtask

  // Monitor: matches control pulses against the scoreboard every cycle.
  bit mon_en = 1'b0;
  always @(negedge CLK) begin
    if (mon_en) begin
      check("ctrl_exclusive", 64'(int'(pc_reset) + int'(pc_write) + int'(ir_load) <= 1), 64'd1);
      check("alu_sel", 64'(alu_sel), pc_write ? 64'd1 : 64'd0);
      if (ir_load) begin
        if (ir_q.size() == 0) check("ir_load_unexpected", 64'(cyc), 64'hFFFF_FFFF);
        else                  check("ir_load_cycle", 64'(cyc), 64'(ir_q.pop_front()));
      end
      if (pc_write) begin
        if (ex_q.size() == 0) check("pc_write_unexpected", 64'(cyc), 64'hFFFF_FFFF);
        else                  check("pc_write_cycle", 64'(cyc), 64'(ex_q.pop_front()));
      end
    end
  end

  logic [6:0] ops [4];
  int f;

  initial begin
    ops[0] = 7'b0110011; ops[1] = 7'b0000011; ops[2] = 7'b1101111; ops[3] = 7'b1110011;
    RST = 1'b1; halt_req = 1'b0; opcode = 7'b0010011;

    // Reset held three cycles
    step(1);
    mon_en = 1'b1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_pc_reset", 64'(pc_reset), 64'd1);
    check("rst_instr_count", 64'(instr_count), 64'd0);
    check("rst_halt_cycles", 64'(halt_cycles), 64'd0);
    check("rst_halted_trap", 64'({halted, trap}), 64'd0);
    step(2);
    RST = 1'b0;
    check("post_rst_pc_reset", 64'(pc_reset), 64'd1);
    step(1);
    check("post_rst_state", 64'(state), 64'd1);
    check("post_rst_pc_reset_low", 64'(pc_reset), 64'd0);

    // Stream of four legal instructions
    f = cyc;
    for (int k = 0; k < 4; k++) expect_instr(f + k * P, 1'b1);
    for (int k = 0; k < 4; k++) begin
      opcode = ops[k];
      step(P);
    end
    check("stream_state", 64'(state), 64'd1);
    check("stream_instr_count", 64'(instr_count), cnt_exp(4));
    check("stream_ir_q_empty", 64'(ir_q.size()), 64'd0);
    check("stream_ex_q_empty", 64'(ex_q.size()), 64'd0);

    // Halt requested during FETCH, held for 7 HALT cycles
    f = cyc;
    opcode = 7'b0010011;
    halt_req = 1'b1;
    expect_instr(f, 1'b1);
    step(P);
    check("halt_state", 64'(state), 64'd5);
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_instr_count", 64'(instr_count), cnt_exp(5));
    step(6);
    check("halt_still", 64'(halted), 64'd1);
    halt_req = 1'b0;
    step(1);
    check("resume_state", 64'(state), 64'd1);
    check("resume_halted", 64'(halted), 64'd0);
    check("halt_cycles", 64'(halt_cycles), cnt_exp(7));
    check("resume_instr_count", 64'(instr_count), cnt_exp(5));

    // One more instruction, then reset while in LOAD_IR
    f = cyc;
    expect_instr(f, 1'b1);
    expect_instr(f + P, 1'b0);
    step(P);
    check("post_halt_instr_count", 64'(instr_count), cnt_exp(6));
    step(L);
    check("load_ir_state", 64'(state), 64'd2);
    check("load_ir_pulse", 64'(ir_load), 64'd1);
    RST = 1'b1;
    step(1);
    check("rst_in_load_state", 64'(state), 64'd0);
    check("rst_in_load_ir_load", 64'(ir_load), 64'd0);
    check("rst_in_load_instr_count", 64'(instr_count), 64'd0);
    check("rst_in_load_halt_cycles", 64'(halt_cycles), 64'd0);
    RST = 1'b0;
    step(1);
    check("rst2_state", 64'(state), 64'd1);

    // Illegal opcode -> sticky trap
    f = cyc;
    opcode = 7'b1111111;
    expect_instr(f, 1'b0);
    step(L + 2);
    check("trap_state", 64'(state), 64'd6);
    check("trap_flag", 64'(trap), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("trap_held", 64'({state, trap, pc_write}), 64'({3'd6, 1'b1, 1'b0}));
    end
    RST = 1'b1;
    step(1);
    check("trap_rst_state", 64'(state), 64'd0);
    check("trap_rst_flag", 64'(trap), 64'd0);
    RST = 1'b0;
    opcode = 7'b0110111;
    step(1);

    // Three instructions after reset
    f = cyc;
    for (int k = 0; k < 3; k++) expect_instr(f + k * P, 1'b1);
    step(3 * P);
    check("final_instr_count", 64'(instr_count), cnt_exp(3));
    check("final_halt_cycles", 64'(halt_cycles), cnt_exp(0));
    check("final_ir_q_empty", 64'(ir_q.size()), 64'd0);
    check("final_ex_q_empty", 64'(ex_q.size()), 64'd0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
